// File: rtl/mux4_source_arbiter.sv
// Four-requester arbiter sharing one MUX4 source selector.
// Select lines settle one cycle before the grant is issued. Arbitration is
// round-robin, with an optional fixed top priority for requester 0.
module mux4_source_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter bit          PRIO0    = 1'b0
) (
    input  logic       MasterClock,
    input  logic       ResetL,
    input  logic [3:0] Req,
    output logic [3:0] Gnt,
    output logic       SelA,
    output logic       SelB,
    output logic       Busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] sel_q, sel_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gnt_d;
    logic       busy_d;

    logic [1:0] arb_idx;
    logic       arb_valid;
    logic       others_pending;
    logic       hold_expired;

    // Arbitration: scan Last+4 down to Last+1 so the nearest requester after Last wins
    always_comb begin
        logic [1:0] cand;
        arb_valid = |Req;
        arb_idx   = last_q;
        cand      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = last_q + 2'(4 - k);
            if (Req[cand]) begin
                arb_idx = cand;
            end
        end
        if (PRIO0 && Req[0]) begin
            arb_idx = 2'd0;
        end
    end

    // Preemption qualifiers while a grant is held
    always_comb begin
        others_pending = |(Req & ~Gnt);
        hold_expired   = 32'(hold_q) >= MAX_HOLD;
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        sel_d     = sel_q;
        winner_d  = winner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        gnt_d     = Gnt;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt = ST_SELECT;
                    sel_d     = arb_idx;
                    winner_d  = arb_idx;
                    gnt_d     = '0;
                end
            end
            ST_SELECT: begin
                if (Req[winner_q]) begin
                    state_nxt = ST_GRANT;
                    gnt_d     = 4'b0001 << winner_q;
                    last_d    = winner_q;
                    hold_d    = 8'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!Req[winner_q] || (hold_expired && others_pending)) begin
                    state_nxt = ST_RELEASE;
                    gnt_d     = '0;
                    hold_d    = '0;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
                gnt_d     = '0;
                hold_d    = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_d     = '0;
                hold_d    = '0;
            end
        endcase
        busy_d = (state_nxt != ST_IDLE);
    end

    // State and output registers; reset clears the grant asynchronously
    always_ff @(posedge MasterClock or negedge ResetL) begin
        if (!ResetL) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            winner_q <= '0;
            last_q   <= 2'd3;
            hold_q   <= '0;
            Gnt      <= '0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel_q    <= sel_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            Gnt      <= gnt_d;
            Busy     <= busy_d;
        end
    end

    assign SelA = sel_q[0];
    assign SelB = sel_q[1];

endmodule
